mdu_seq: RTL and testbench

- Multi-cycle multiply/divide sequencer beside the single-cycle ALU in the cpu2 execute stage.
- Handles the MUL/DIV op group the combinational ALU cannot: unsigned shift-add multiply and restoring divide, one bit per cycle.
- Start/busy/done handshake lets the execute controller stall.
- Result, flags, wb_en and flag_en follow the same conventions as the ALU outputs, so writeback muxes them directly.

---
 rtl/mdu_seq_if.sv | 30 +++
 rtl/mdu_seq.sv | 160 ++++++++++++++++
 tb/tb_mdu_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_seq_if.sv
// Handshake and operand bus between the execute controller and the
// multi-cycle multiply/divide sequencer.
interface mdu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             flush;
    logic [1:0]       func;
    logic [WIDTH-1:0] di;
    logic [WIDTH-1:0] bi;
    logic [7:0]       fi;
    logic [WIDTH-1:0] res;
    logic [7:0]       fo;
    logic             busy;
    logic             done;
    logic             wb_en;
    logic             flag_en;

    // Execute-stage controller side: issues requests, consumes results.
    modport master (
        output start, flush, func, di, bi, fi,
        input  res, fo, busy, done, wb_en, flag_en
    );

    // Sequencer side.
    modport slave (
        input  start, flush, func, di, bi, fi,
        output res, fo, busy, done, wb_en, flag_en
    );
endinterface

// File: rtl/mdu_seq.sv
// Multi-cycle unsigned multiply / restoring divide sequencer, one bit per
// cycle. Outputs follow the ALU result/flag conventions so writeback can
// mux them directly while done is high.
module mdu_seq #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic      clk,
    input  logic      reset,
    mdu_seq_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    localparam logic [CNTW-1:0] LAST_ITER = CNTW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_latch;
    logic             w_iter;
    logic             w_finish;

    // Working registers. For MUL {hi,lo} is the product with the multiplier
    // preloaded in lo; for DIV hi is the partial remainder and lo holds the
    // dividend shifting out of the top while quotient bits enter the bottom.
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_func;
    logic [7:3]       r_fi;
    logic             r_dz;
    logic [CNTW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_res;
    logic [7:0]       r_fo;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_sub;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic [7:0]       w_fo;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and control strobes; flush wins over everything else.
    always_comb begin
        // NOTE: defaults first so no path through the case infers a latch.
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_iter      = 1'b0;
        w_finish    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    w_state_nxt = S_IDLE;
                end else if (r_dz) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_iter = 1'b1;
                    if (r_cnt == LAST_ITER) begin
                        w_finish    = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One shift-add / restoring-divide step and result/flag formation.
    always_comb begin
        w_sum     = {1'b0, r_hi} + {1'b0, r_b};
        w_add     = r_lo[0] ? w_sum : {1'b0, r_hi};
        w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
        w_ge      = (w_rem_sh >= {1'b0, r_b});
        // When w_ge holds the difference always fits in WIDTH bits.
        w_rem_sub = w_rem_sh[WIDTH-1:0] - r_b;
        if (r_func[1]) begin
            w_hi_nxt = w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            w_hi_nxt = w_add[WIDTH:1];
            w_lo_nxt = {w_add[0], r_lo[WIDTH-1:1]};
        end
        w_carry = 1'b0;
        if (r_dz) begin
            w_res   = r_func[0] ? r_lo : '1;
            w_carry = 1'b1;
        end else begin
            unique case (r_func)
                2'b00: begin
                    w_res   = w_lo_nxt;
                    w_carry = |w_hi_nxt;
                end
                2'b01:   w_res = w_hi_nxt;
                2'b10:   w_res = w_lo_nxt;
                default: w_res = w_hi_nxt;
            endcase
        end
        w_fo = {r_fi, w_res[WIDTH-1], (w_res == '0), w_carry};
    end

    // Operand latch, iteration datapath and result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_b    <= '0;
            r_func <= '0;
            r_fi   <= '0;
            r_dz   <= 1'b0;
            r_cnt  <= '0;
            r_res  <= '0;
            r_fo   <= '0;
        end else begin
            if (w_latch) begin
                r_hi   <= '0;
                r_lo   <= bus.func[1] ? bus.di : bus.bi;
                r_b    <= bus.func[1] ? bus.bi : bus.di;
                r_func <= bus.func;
                r_fi   <= bus.fi[7:3];
                r_dz   <= bus.func[1] && (bus.bi == '0);
                r_cnt  <= '0;
            end else if (w_iter) begin
                r_hi  <= w_hi_nxt;
                r_lo  <= w_lo_nxt;
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_finish) begin
                r_res <= w_res;
                r_fo  <= w_fo;
            end
        end
    end

    logic w_done;
    assign w_done      = (r_state == S_DONE) && !bus.flush;
    assign bus.done    = w_done;
    assign bus.wb_en   = w_done;
    assign bus.flag_en = w_done;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.res     = r_res;
    assign bus.fo      = r_fo;
endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq (WIDTH=32). Latency k counts
// rising edges after the start edge until done is seen (done in cycle k+1
// when the start cycle is cycle 1).
module tb_mdu_seq;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    mdu_seq_if #(.WIDTH(32)) bus ();

    mdu_seq #(.WIDTH(32), .CNTW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Issue one operation, scramble the inputs after the start edge, and wait
    // (bounded) for done. Returns observed values to the calling test task.
    task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [7:0] fl, output logic [31:0] res, output logic [7:0] fo,
                          output int lat, output int busy_cnt, output logic strobes,
                          output logic done_after);
        bit got;
        got = 0; lat = -1; busy_cnt = 0; res = '0; fo = '0; strobes = 1'b0; done_after = 1'b1;
        @(negedge clk);
        bus.func = f; bus.di = a; bus.bi = b; bus.fi = fl; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.di = ~a; bus.bi = ~b; bus.func = ~f; bus.fi = ~fl;
        for (int k = 0; k < 100 && !got; k++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                got = 1; lat = k; res = bus.res; fo = bus.fo;
                strobes = bus.wb_en && bus.flag_en;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (got) begin
            @(posedge clk); #1;
            done_after = bus.done | bus.wb_en | bus.flag_en;
        end
    endtask

    task automatic test_reset();
        bus.start = 0; bus.flush = 0; bus.func = 0; bus.di = 0; bus.bi = 0; bus.fi = 0;
        repeat (2) @(negedge clk);
        checks++; if (bus.res !== 32'h0) begin failures++; $display("FAIL reset_res got=%0h exp=0", bus.res); end
        checks++; if (bus.fo !== 8'h0) begin failures++; $display("FAIL reset_fo got=%0h exp=0", bus.fo); end
        checks++; if ({bus.busy, bus.done, bus.wb_en, bus.flag_en} !== 4'b0000) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0000", {bus.busy, bus.done, bus.wb_en, bus.flag_en});
        end
        reset = 1'b0;
    endtask

    task automatic test_mul_basic();
        logic [31:0] r; logic [7:0] fo; int lat, bc; logic st, da;
        run_op(2'b00, 32'd7, 32'd6, 8'h00, r, fo, lat, bc, st, da);
        checks++; if (lat !== 32) begin failures++; $display("FAIL mul_latency got=%0d exp=32", lat); end
        checks++; if (bc !== 33) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=33", bc); end
        checks++; if (r !== 32'd42) begin failures++; $display("FAIL mul_7x6_res got=%0d exp=42", r); end
        checks++; if (fo !== 8'h00) begin failures++; $display("FAIL mul_7x6_fo got=%0h exp=00", fo); end
        checks++; if (st !== 1'b1) begin failures++; $display("FAIL mul_strobes got=%b exp=1", st); end
        checks++; if (da !== 1'b0) begin failures++; $display("FAIL mul_done_one_cycle got=%b exp=0", da); end
    endtask

    task automatic test_mul_wide();
        logic [31:0] r; logic [7:0] fo; int lat, bc; logic st, da;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h00, r, fo, lat, bc, st, da);
        checks++; if (r !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mulh_res got=%0h exp=fffffffe", r); end
        checks++; if (fo !== 8'h04) begin failures++; $display("FAIL mulh_fo got=%0h exp=04", fo); end
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h00, r, fo, lat, bc, st, da);
        checks++; if (r !== 32'h0000_0001) begin failures++; $display("FAIL mull_res got=%0h exp=1", r); end
        checks++; if (fo !== 8'h01) begin failures++; $display("FAIL mull_fo got=%0h exp=01", fo); end
    endtask

    task automatic test_div();
        logic [31:0] r; logic [7:0] fo; int lat, bc; logic st, da;
        run_op(2'b10, 32'd100, 32'd7, 8'h00, r, fo, lat, bc, st, da);
        checks++; if (lat !== 32) begin failures++; $display("FAIL div_latency got=%0d exp=32", lat); end
        checks++; if (r !== 32'd14) begin failures++; $display("FAIL div_quo got=%0d exp=14", r); end
        checks++; if (fo !== 8'h00) begin failures++; $display("FAIL div_quo_fo got=%0h exp=00", fo); end
        run_op(2'b11, 32'd100, 32'd7, 8'h00, r, fo, lat, bc, st, da);
        checks++; if (r !== 32'd2) begin failures++; $display("FAIL div_rem got=%0d exp=2", r); end
        run_op(2'b11, 32'd5, 32'd5, 8'h00, r, fo, lat, bc, st, da);
        checks++; if (r !== 32'd0) begin failures++; $display("FAIL div_rem_zero got=%0d exp=0", r); end
        checks++; if (fo !== 8'h02) begin failures++; $display("FAIL div_rem_zero_fo got=%0h exp=02", fo); end
    endtask

    task automatic test_div_zero();
        logic [31:0] r; logic [7:0] fo; int lat, bc; logic st, da;
        run_op(2'b10, 32'h1234, 32'h0, 8'h00, r, fo, lat, bc, st, da);
        checks++; if (lat !== 1) begin failures++; $display("FAIL dz_latency got=%0d exp=1", lat); end
        checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL dz_quo got=%0h exp=ffffffff", r); end
        checks++; if (fo !== 8'h05) begin failures++; $display("FAIL dz_quo_fo got=%0h exp=05", fo); end
        checks++; if (da !== 1'b0) begin failures++; $display("FAIL dz_done_one_cycle got=%b exp=0", da); end
        run_op(2'b11, 32'h1234, 32'h0, 8'h00, r, fo, lat, bc, st, da);
        checks++; if (r !== 32'h1234) begin failures++; $display("FAIL dz_rem got=%0h exp=1234", r); end
        checks++; if (fo !== 8'h01) begin failures++; $display("FAIL dz_rem_fo got=%0h exp=01", fo); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic [7:0] fo; int lat, bc; logic st, da;
        bit got; bit seen;
        // Operation A with a competing start at k=5.
        @(negedge clk);
        bus.func = 2'b10; bus.di = 32'd100; bus.bi = 32'd7; bus.fi = 8'h00; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        bus.func = 2'b00; bus.di = 32'd9; bus.bi = 32'd9; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        got = 0; lat = -1;
        for (int k = 5; k < 100 && !got; k++) begin
            if (bus.done) begin got = 1; lat = k; r = bus.res; end
            else begin @(posedge clk); #1; end
        end
        checks++; if (lat !== 32) begin failures++; $display("FAIL b2b_latency got=%0d exp=32", lat); end
        checks++; if (r !== 32'd14) begin failures++; $display("FAIL b2b_res got=%0d exp=14", r); end
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_no_queued_start got=%b exp=0", bus.busy); end
        // Operation B flushed at k=10.
        @(negedge clk);
        bus.func = 2'b00; bus.di = 32'd3; bus.bi = 32'd5; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        @(negedge clk); bus.flush = 1'b1;
        @(posedge clk); #1; bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL flush_idle got=%b exp=0", bus.busy); end
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done || bus.wb_en || bus.flag_en) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_no_done got=%b exp=0", seen); end
        // Operation C accepted normally afterwards.
        run_op(2'b00, 32'd11, 32'd13, 8'h00, r, fo, lat, bc, st, da);
        checks++; if (r !== 32'd143) begin failures++; $display("FAIL post_flush_res got=%0d exp=143", r); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; logic [7:0] fo; int lat, bc; logic st, da;
        bit seen;
        @(negedge clk);
        bus.func = 2'b00; bus.di = 32'h0001_0001; bus.bi = 32'h30; bus.fi = 8'hA0; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        @(negedge clk); reset = 1'b1; #1;
        checks++; if (bus.res !== 32'h0) begin failures++; $display("FAIL rst_mid_res got=%0h exp=0", bus.res); end
        checks++; if (bus.fo !== 8'h0) begin failures++; $display("FAIL rst_mid_fo got=%0h exp=0", bus.fo); end
        checks++; if ({bus.busy, bus.done, bus.wb_en, bus.flag_en} !== 4'b0000) begin
            failures++; $display("FAIL rst_mid_ctrl got=%b exp=0000", {bus.busy, bus.done, bus.wb_en, bus.flag_en});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_no_done got=%b exp=0", seen); end
        run_op(2'b00, 32'd3, 32'd3, 8'hA0, r, fo, lat, bc, st, da);
        checks++; if (r !== 32'd9) begin failures++; $display("FAIL rst_after_res got=%0d exp=9", r); end
        checks++; if (fo !== 8'hA0) begin failures++; $display("FAIL rst_after_fo got=%0h exp=a0", fo); end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_mul_wide();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
